// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared FSM, port-select, IO-space and length encodings for mem_ctrl
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  typedef enum logic {SEL_IF, SEL_MEM} sel_t;
  localparam logic [31:0] IO_BASE = 32'h0003_0000;
  localparam logic [2:0] LEN1 = 3'd1;
  localparam logic [2:0] LEN2 = 3'd2;
  localparam logic [2:0] LEN4 = 3'd4;
  function automatic logic [2:0] norm_len(input logic [2:0] l);
    return (l == LEN1 || l == LEN2) ? l : LEN4;
  endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: fetch, load/store and byte-wide RAM bus signals of mem_ctrl
interface mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        if_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [2:0]  mem_len;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_stall;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_len, mem_wdata, ram_din,
    input  if_data, if_done, if_stall, mem_rdata, mem_done, mem_stall, ram_dout, ram_a, ram_wr
  );
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_len, mem_wdata, ram_din,
    output if_data, if_done, if_stall, mem_rdata, mem_done, mem_stall, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial IF/MEM arbiter onto an 8-bit RAM bus; IO_BUF_FULL_EN adds UART back-pressure
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
`ifdef IO_BUF_FULL_EN
  input  logic io_buffer_full,
`endif
  mem_ctrl_if.slave bus
);
  state_t      state_q, state_d;
  sel_t        sel_q, sel_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic [1:0]  lane;
  logic        io_wait;
  logic        issue;
`ifdef IO_BUF_FULL_EN
  assign io_wait = state_q == WR && a_q[17:16] == IO_BASE[17:16] && io_buffer_full;
`else
  assign io_wait = 1'b0;
`endif
  assign issue = state_q == WR && !io_wait;
  assign lane = (state_q == RD) ? cnt_q[1:0] - 2'd1 : cnt_q[1:0];
  assign bus.ram_a = a_q;
  assign bus.ram_wr = rdy_in && issue;
  assign bus.ram_dout = wdata_q[{lane, 3'b000} +: 8];
  assign bus.if_data = rdata_q;
  assign bus.mem_rdata = rdata_q;
  assign bus.if_done = if_done_q;
  assign bus.mem_done = mem_done_q;
  assign bus.if_stall = bus.if_req && !if_done_q;
  assign bus.mem_stall = bus.mem_req && !mem_done_q;
  // arbitration in IDLE, byte issue/capture in RD and WR, done pulse on the last byte
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    len_d = len_q;
    cnt_d = cnt_q;
    a_d = a_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if_done_d = 1'b0;
    mem_done_d = 1'b0;
    if (state_q == IDLE && !if_done_q && !mem_done_q && (bus.mem_req || bus.if_req)) begin
      sel_d = bus.mem_req ? SEL_MEM : SEL_IF;
      state_d = (bus.mem_req && bus.mem_we) ? WR : RD;
      len_d = bus.mem_req ? norm_len(bus.mem_len) : LEN4;
      a_d = bus.mem_req ? bus.mem_addr : bus.if_addr;
      wdata_d = bus.mem_wdata;
      rdata_d = '0;
      cnt_d = '0;
    end else if (state_q == RD) begin
      if (cnt_q != 3'd0) rdata_d[{lane, 3'b000} +: 8] = bus.ram_din;
      cnt_d = cnt_q + 3'd1;
      if (cnt_q + 3'd1 < len_q) a_d = a_q + 32'd1;
      if (cnt_q == len_q) begin
        state_d = IDLE;
        if_done_d = sel_q == SEL_IF;
        mem_done_d = sel_q == SEL_MEM;
      end
    end else if (issue) begin
      cnt_d = cnt_q + 3'd1;
      if (cnt_q + 3'd1 == len_q) begin
        state_d = IDLE;
        if_done_d = sel_q == SEL_IF;
        mem_done_d = sel_q == SEL_MEM;
      end else a_d = a_q + 32'd1;
    end
  end
  // state register; everything freezes while rdy_in is low
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      sel_q <= SEL_IF;
      len_q <= '0;
      cnt_q <= '0;
      a_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      if_done_q <= 1'b0;
      mem_done_q <= 1'b0;
    end else if (rdy_in) begin
      state_q <= state_d;
      sel_q <= sel_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      if_done_q <= if_done_d;
      mem_done_q <= mem_done_d;
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl
module tb_mem_ctrl;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic io_buffer_full;
  logic [7:0] ram [0:511];
  int tests = 0;
  int fails = 0;
  mem_ctrl_if b();
  mem_ctrl dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
`ifdef IO_BUF_FULL_EN
    .io_buffer_full(io_buffer_full),
`endif
    .bus(b)
  );
  always #5 clk_in = ~clk_in;
  // synchronous RAM, stalled by the same global ready
  always @(posedge clk_in) if (rdy_in) b.ram_din <= ram[b.ram_a[8:0]];
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 8'h00;
    ram[9'h100] = 8'h13; ram[9'h101] = 8'h00; ram[9'h102] = 8'h00; ram[9'h103] = 8'h93;
    ram[9'h020] = 8'hFF;
    ram[9'h1FE] = 8'hA1; ram[9'h1FF] = 8'hB2; ram[9'h000] = 8'hC3; ram[9'h001] = 8'hD4;
    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
    b.if_req = 1'b0; b.if_addr = '0; b.mem_req = 1'b0; b.mem_we = 1'b0;
    b.mem_addr = '0; b.mem_len = 3'd0; b.mem_wdata = '0;
    tick; tick;
    check("rst_ram_a", b.ram_a, 32'h0);
    check("rst_ram_wr", {31'd0, b.ram_wr}, 32'd0);
    check("rst_dones", {30'd0, b.if_done, b.mem_done}, 32'd0);
    check("rst_data", b.if_data, 32'h0);
    rst_in = 1'b0;
    tick;
    // 4-byte fetch from 0x100
    b.if_req = 1'b1; b.if_addr = 32'h100;
    tick;
    for (int i = 0; i < 4; i++) begin
      check("f_ram_a", b.ram_a, 32'h100 + i);
      check("f_stall", {31'd0, b.if_stall}, 32'd1);
      tick;
    end
    check("f_done_c5", {31'd0, b.if_done}, 32'd0);
    tick;
    check("f_done_c6", {31'd0, b.if_done}, 32'd1);
    check("f_data", b.if_data, 32'h93000013);
    check("f_stall_done", {31'd0, b.if_stall}, 32'd0);
    b.if_req = 1'b0;
    tick;
    check("f_done_pulse", {31'd0, b.if_done}, 32'd0);
    // simultaneous IF and 1-byte MEM load: MEM first, then IF after the bubble
    b.if_req = 1'b1; b.if_addr = 32'h100;
    b.mem_req = 1'b1; b.mem_we = 1'b0; b.mem_addr = 32'h20; b.mem_len = 3'd1;
    tick;
    check("a_ram_a", b.ram_a, 32'h20);
    check("a_stall_c1", {31'd0, b.if_stall}, 32'd1);
    tick;
    check("a_stall_c2", {31'd0, b.if_stall}, 32'd1);
    tick;
    check("a_mem_done", {31'd0, b.mem_done}, 32'd1);
    check("a_mem_rdata", b.mem_rdata, 32'h000000FF);
    check("a_if_done_c3", {31'd0, b.if_done}, 32'd0);
    check("a_stall_c3", {31'd0, b.if_stall}, 32'd1);
    b.mem_req = 1'b0;
    tick;
    check("a_stall_c4", {31'd0, b.if_stall}, 32'd1);
    check("a_mem_pulse", {31'd0, b.mem_done}, 32'd0);
    tick;
    check("a_if_ram_a", b.ram_a, 32'h100);
    for (int i = 0; i < 5; i++) begin
      check("a_stall_if", {31'd0, b.if_stall}, 32'd1);
      check("a_if_early", {31'd0, b.if_done}, 32'd0);
      tick;
    end
    check("a_if_done", {31'd0, b.if_done}, 32'd1);
    check("a_if_data", b.if_data, 32'h93000013);
    b.if_req = 1'b0;
    tick;
    // 2-byte store at 0x1FE
    b.mem_req = 1'b1; b.mem_we = 1'b1; b.mem_addr = 32'h1FE; b.mem_len = 3'd2;
    b.mem_wdata = 32'hAABBCCDD;
    tick;
    check("s_wr_c1", {31'd0, b.ram_wr}, 32'd1);
    check("s_a_c1", b.ram_a, 32'h1FE);
    check("s_d_c1", {24'd0, b.ram_dout}, 32'hDD);
    tick;
    check("s_wr_c2", {31'd0, b.ram_wr}, 32'd1);
    check("s_a_c2", b.ram_a, 32'h1FF);
    check("s_d_c2", {24'd0, b.ram_dout}, 32'hCC);
    check("s_done_c2", {31'd0, b.mem_done}, 32'd0);
    tick;
    check("s_wr_c3", {31'd0, b.ram_wr}, 32'd0);
    check("s_done_c3", {31'd0, b.mem_done}, 32'd1);
    b.mem_req = 1'b0;
    tick;
    // fetch with rdy_in low for three edges starting in cycle 2
    b.if_req = 1'b1; b.if_addr = 32'h100;
    tick; tick;
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("r_hold_a", b.ram_a, 32'h101);
      check("r_hold_wr", {31'd0, b.ram_wr}, 32'd0);
      check("r_hold_done", {31'd0, b.if_done}, 32'd0);
    end
    rdy_in = 1'b1;
    tick; tick; tick;
    check("r_done_c8", {31'd0, b.if_done}, 32'd0);
    tick;
    check("r_done_c9", {31'd0, b.if_done}, 32'd1);
    check("r_data", b.if_data, 32'h93000013);
    b.if_req = 1'b0;
    tick;
    // rdy_in low gates ram_wr during a store
    b.mem_req = 1'b1; b.mem_we = 1'b1; b.mem_addr = 32'h50; b.mem_len = 3'd1;
    b.mem_wdata = 32'h0000005C;
    tick;
    rdy_in = 1'b0;
    #1;
    check("g_wr_low", {31'd0, b.ram_wr}, 32'd0);
    tick;
    check("g_wr_frozen", {31'd0, b.ram_wr}, 32'd0);
    check("g_done_frozen", {31'd0, b.mem_done}, 32'd0);
    rdy_in = 1'b1;
    #1;
    check("g_wr_back", {31'd0, b.ram_wr}, 32'd1);
    check("g_dout", {24'd0, b.ram_dout}, 32'h5C);
    tick;
    check("g_done", {31'd0, b.mem_done}, 32'd1);
    b.mem_req = 1'b0;
    tick;
    // reset in cycle 2 of a 4-byte store
    b.mem_req = 1'b1; b.mem_we = 1'b1; b.mem_addr = 32'h40; b.mem_len = 3'd4;
    b.mem_wdata = 32'h11223344;
    tick;
    check("x_d_c1", {24'd0, b.ram_dout}, 32'h44);
    tick;
    check("x_a_c2", b.ram_a, 32'h41);
    check("x_d_c2", {24'd0, b.ram_dout}, 32'h33);
    rst_in = 1'b1; b.mem_req = 1'b0;
    tick;
    check("x_wr", {31'd0, b.ram_wr}, 32'd0);
    check("x_stalls", {30'd0, b.if_stall, b.mem_stall}, 32'd0);
    check("x_dones", {30'd0, b.if_done, b.mem_done}, 32'd0);
    check("x_ram_a", b.ram_a, 32'h0);
    rst_in = 1'b0;
    tick;
    // length 3 treated as 4, address wraps past 0xFFFFFFFF
    b.mem_req = 1'b1; b.mem_we = 1'b0; b.mem_addr = 32'hFFFFFFFE; b.mem_len = 3'd3;
    tick;
    for (int i = 0; i < 4; i++) begin
      check("w_ram_a", b.ram_a, 32'hFFFFFFFE + i);
      tick;
    end
    check("w_done_c5", {31'd0, b.mem_done}, 32'd0);
    tick;
    check("w_done_c6", {31'd0, b.mem_done}, 32'd1);
    check("w_rdata", b.mem_rdata, 32'hD4C3B2A1);
    b.mem_req = 1'b0;
    tick;
`ifdef IO_BUF_FULL_EN
    // 1-byte IO store held off by io_buffer_full for four cycles
    b.mem_req = 1'b1; b.mem_we = 1'b1; b.mem_addr = 32'h30000; b.mem_len = 3'd1;
    b.mem_wdata = 32'h00000041; io_buffer_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("io_wait_wr", {31'd0, b.ram_wr}, 32'd0);
      check("io_wait_done", {31'd0, b.mem_done}, 32'd0);
    end
    io_buffer_full = 1'b0;
    #1;
    check("io_wr", {31'd0, b.ram_wr}, 32'd1);
    check("io_a", b.ram_a, 32'h30000);
    check("io_d", {24'd0, b.ram_dout}, 32'h41);
    tick;
    check("io_done", {31'd0, b.mem_done}, 32'd1);
    b.mem_req = 1'b0;
    tick;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
